// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder_pkg: shared FSM state type and counter width.   Rev 1.0
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int WIDTH_MAX = 32;
  localparam int CNT_W     = $clog2(WIDTH_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/add_bit_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_bit_cell: single-bit full adder (sum and carry).   Rev 1.0
// ---------------------------------------------------------------------------
module add_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half;

  assign half = a ^ b;
  assign s    = half ^ ci;
  assign co   = (a & b) | (ci & half);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// SERIAL_ADDER_OVF_EN adds out_ovf (signed overflow).   Rev 1.0
// ---------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             ready_q;
  logic             cell_s;
  logic             cell_co;

  add_bit_cell u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // Gated so no handshake can be seen while reset is asserted.
  assign in_ready = ready_q & ~sys_rst;
  assign s_next   = {cell_s, s_sr[WIDTH-1:1]};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && ready_q) begin
            a_sr    <= in_a;
            b_sr    <= in_b;
            s_sr    <= '0;
            carry   <= in_cin;
            cnt     <= CNT_W'(WIDTH - 1);
            ready_q <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_next;
          carry <= cell_co;
          if (cnt == '0) begin
            // Last bit: carry still holds the carry into the MSB.
            out_valid <= 1'b1;
            out_sum   <= s_next;
            out_cout  <= cell_co;
`ifdef SERIAL_ADDER_OVF_EN
            out_ovf   <= carry ^ cell_co;
`endif
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ready_q   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          ready_q   <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8).   Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         sys_clk;
  logic         sys_rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference: full-precision unsigned sum; bit W is the carry out.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, b, input logic cin);
    int unsigned t;
    t = int'(a) + int'(b) + int'(cin);
    return t[W:0];
  endfunction

  // Reference: signed overflow when the true signed result leaves the W-bit range.
  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic cin);
    int r;
    r = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return (r > 127) || (r < -128);
  endfunction

  // Presents one operand set, waits for the result, consumes it.
  // lat counts edges from the edge that opens the accepting cycle.
  task automatic run_add(input logic [W-1:0] a, b, input logic cin,
                         output logic [W-1:0] s, output logic co, output logic ov,
                         output int lat, output bit timeout);
    int n;
    bit acc;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b1;
    acc = 1'b0; n = 0; timeout = 1'b0; s = '0; co = 1'b0; ov = 1'b0;
    while (!acc && n < 50) begin
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!acc || !out_valid) timeout = 1'b1;
    s  = out_sum;
    co = out_cout;
`ifdef SERIAL_ADDER_OVF_EN
    ov = out_ovf;
`endif
    tick();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (2) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_sum !== 8'h00) begin errors++; $display("FAIL reset_out_sum got %h want 00", out_sum); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
`endif
    sys_rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [W-1:0] va [4] = '{8'h5A, 8'hFF, 8'hFF, 8'h00};
    logic [W-1:0] vb [4] = '{8'h3C, 8'h01, 8'h00, 8'h00};
    logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] s;
    logic [W:0]   e;
    logic         co, ov;
    int           lat;
    bit           to;
    for (int i = 0; i < 4; i++) begin
      run_add(va[i], vb[i], vc[i], s, co, ov, lat, to);
      e = ref_sum(va[i], vb[i], vc[i]);
      checks++; if (to) begin errors++; $display("FAIL basic_timeout vec %0d got timeout want result", i); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency vec %0d got %0d want 9", i, lat); end
      checks++; if (s !== e[W-1:0]) begin errors++; $display("FAIL basic_sum vec %0d got %h want %h", i, s, e[W-1:0]); end
      checks++; if (co !== e[W]) begin errors++; $display("FAIL basic_cout vec %0d got %b want %b", i, co, e[W]); end
    end
    // First vector also against the literal answer from hand arithmetic.
    checks++; if (ref_sum(va[0], vb[0], vc[0]) !== 9'h096 || s !== 8'h00) begin
      errors++; $display("FAIL basic_literal got %h/%h want 096/00", ref_sum(va[0], vb[0], vc[0]), s);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit acc;
    in_a = 8'hC3; in_b = 8'h5A; in_cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin acc = in_ready; tick(); n++; end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin tick(); n++; end
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_timeout got out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b want 1", i, out_valid); end
      checks++; if (out_sum !== 8'h1E) begin errors++; $display("FAIL bp_sum cyc %0d got %h want 1e", i, out_sum); end
      checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL bp_cout cyc %0d got %b want 1", i, out_cout); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, in_ready); end
      in_valid = i[0];
      in_a = 8'($urandom); in_b = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    checks++; if (out_sum !== 8'h1E) begin errors++; $display("FAIL bp_retain_sum got %h want 1e", out_sum); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit acc;
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    bit to;
    in_a = 8'h12; in_b = 8'h34; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin acc = in_ready; tick(); n++; end
    in_valid = 1'b0;
    repeat (3) tick();
    sys_rst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (out_sum !== 8'h00) begin errors++; $display("FAIL midrst_out_sum got %h want 00", out_sum); end
    sys_rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got in_ready=%b want 1", in_ready); end
    run_add(8'h01, 8'h01, 1'b0, s, co, ov, lat, to);
    checks++; if (to || s !== 8'h02 || co !== 1'b0) begin
      errors++; $display("FAIL midrst_after got sum=%h cout=%b to=%0d want 02/0/0", s, co, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] q[$];
    int sent = 0, got = 0, last = -1;
    bit acc;
    in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || {out_cout, out_sum} !== q[0]) begin
          errors++; $display("FAIL b2b_result %0d got %h want %h", got, {out_cout, out_sum}, (q.size() != 0) ? q[0] : 9'h000);
        end
        if (q.size() != 0) void'(q.pop_front());
        if (last >= 0) begin
          checks++; if (cyc - last !== 10) begin errors++; $display("FAIL b2b_spacing got %0d want 10", cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (in_ready && out_valid) begin
        errors++; $display("FAIL b2b_overlap got in_ready=1 out_valid=1 want not both");
      end
      acc = in_ready && in_valid;
      if (acc) q.push_back(ref_sum(in_a, in_b, in_cin));
      tick();
      if (acc) begin
        sent++;
        if (sent < 20) begin
          in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++; if (got !== 20) begin errors++; $display("FAIL b2b_count got %0d want 20", got); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic         cin, co, ov;
    logic [W:0]   e;
    int           lat;
    bit           to;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      run_add(a, b, cin, s, co, ov, lat, to);
      e = ref_sum(a, b, cin);
      checks++;
      if (to || s !== e[W-1:0] || co !== e[W]) begin
        errors++; $display("FAIL rand %0d a=%h b=%h cin=%b got %b%h want %b%h", i, a, b, cin, co, s, e[W], e[W-1:0]);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (ov !== ref_ovf(a, b, cin)) begin
        errors++; $display("FAIL rand_ovf %0d got %b want %b", i, ov, ref_ovf(a, b, cin));
      end
`endif
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] va [3] = '{8'h7F, 8'h80, 8'h10};
    logic [W-1:0] vb [3] = '{8'h01, 8'h80, 8'h20};
    logic [W-1:0] ws [3] = '{8'h80, 8'h00, 8'h30};
    logic         wc [3] = '{1'b0, 1'b1, 1'b0};
    logic         wo [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    bit           to;
    for (int i = 0; i < 3; i++) begin
      run_add(va[i], vb[i], 1'b0, s, co, ov, lat, to);
      checks++;
      if (to || s !== ws[i] || co !== wc[i] || ov !== wo[i]) begin
        errors++; $display("FAIL ovf vec %0d got sum=%h cout=%b ovf=%b want %h/%b/%b", i, s, co, ov, ws[i], wc[i], wo[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
